// File: rtl/immediate_decode_stage_pkg.sv
// Shared definitions for the immediate decode stage: format codes, major
// opcode constants and an XLEN legality helper.
package immediate_decode_stage_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6
    } fmt_e;

    // Major opcodes, instr[6:2]
    localparam logic [4:0] OPC_LOAD      = 5'b00000;
    localparam logic [4:0] OPC_MISC_MEM  = 5'b00011;
    localparam logic [4:0] OPC_OP_IMM    = 5'b00100;
    localparam logic [4:0] OPC_AUIPC     = 5'b00101;
    localparam logic [4:0] OPC_OP_IMM_32 = 5'b00110;
    localparam logic [4:0] OPC_STORE     = 5'b01000;
    localparam logic [4:0] OPC_OP        = 5'b01100;
    localparam logic [4:0] OPC_LUI       = 5'b01101;
    localparam logic [4:0] OPC_OP_32     = 5'b01110;
    localparam logic [4:0] OPC_BRANCH    = 5'b11000;
    localparam logic [4:0] OPC_JALR      = 5'b11001;
    localparam logic [4:0] OPC_JAL       = 5'b11011;
    localparam logic [4:0] OPC_SYSTEM    = 5'b11100;

    function automatic bit xlen_is_legal(input int unsigned xlen);
        return (xlen == 32'd32) || (xlen == 32'd64);
    endfunction

endpackage

// File: rtl/immediate_decode_stage_imm_format_decode.sv
// Combinational instruction -> {immediate, format, illegal} decoder.
// Every format is assembled into a 32-bit signed value, then sign-extended to XLEN.
module imm_format_decode
    import immediate_decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit CSR_IMM_EN = 1'b1
) (
    input  logic [31:0]     instr_i,
    output logic [XLEN-1:0] imm_o,
    output logic [2:0]      type_o,
    output logic            illegal_o
);

    localparam bit IS_RV64 = (XLEN == 32'd64);

    logic [4:0]  opcode;
    logic [2:0]  funct3;
    logic        is_shift;
    fmt_e        fmt;
    logic        illegal;
    logic [31:0] raw;

    // Format classification from the major opcode and funct3
    always_comb begin
        opcode   = instr_i[6:2];
        funct3   = instr_i[14:12];
        fmt      = FMT_R;
        illegal  = 1'b0;
        is_shift = 1'b0;
        if (instr_i[1:0] != 2'b11) begin
            illegal = 1'b1;
        end else begin
            case (opcode)
                OPC_OP_IMM: begin
                    fmt      = FMT_I;
                    is_shift = (funct3[1:0] == 2'b01);
                end
                OPC_LOAD, OPC_JALR:      fmt = FMT_I;
                OPC_STORE:               fmt = FMT_S;
                OPC_BRANCH:              fmt = FMT_B;
                OPC_LUI, OPC_AUIPC:      fmt = FMT_U;
                OPC_JAL:                 fmt = FMT_J;
                OPC_OP, OPC_MISC_MEM:    fmt = FMT_R;
                OPC_SYSTEM: begin
                    if (funct3 == 3'b000) begin
                        fmt = FMT_R;
                    end else if (funct3[2] && CSR_IMM_EN) begin
                        fmt = FMT_Z;
                    end else begin
                        fmt = FMT_I;
                    end
                end
                OPC_OP_IMM_32: begin
                    if (IS_RV64) begin
                        fmt = FMT_I;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                OPC_OP_32: begin
                    if (IS_RV64) begin
                        fmt = FMT_R;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                default: illegal = 1'b1;
            endcase
        end
    end

    // Immediate assembly; shift amounts and zimm have a clear bit 31 so the
    // common sign extension leaves them zero-extended
    always_comb begin
        raw = 32'd0;
        case (fmt)
            FMT_I: begin
                if (is_shift) begin
                    raw = IS_RV64 ? {26'd0, instr_i[25:20]} : {27'd0, instr_i[24:20]};
                end else begin
                    raw = {{20{instr_i[31]}}, instr_i[31:20]};
                end
            end
            FMT_S:   raw = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            FMT_B:   raw = {{19{instr_i[31]}}, instr_i[31], instr_i[7], instr_i[30:25],
                            instr_i[11:8], 1'b0};
            FMT_U:   raw = {instr_i[31:12], 12'd0};
            FMT_J:   raw = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12], instr_i[20],
                            instr_i[30:21], 1'b0};
            FMT_Z:   raw = {27'd0, instr_i[19:15]};
            default: raw = 32'd0;
        endcase
    end

    assign imm_o     = illegal ? '0 : XLEN'($signed(raw));
    assign type_o    = illegal ? FMT_R : fmt;
    assign illegal_o = illegal;

endmodule

// File: rtl/immediate_decode_stage.sv
// Registered immediate decode stage with valid/ready handshakes, flush and a
// two-entry (output + skid) buffer so throughput survives backpressure.
module immediate_decode_stage
    import immediate_decode_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter bit CSR_IMM_EN = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_type,
    output logic            out_illegal
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;
    logic            dec_illegal;

    imm_format_decode #(
        .XLEN       (XLEN),
        .CSR_IMM_EN (CSR_IMM_EN)
    ) u_decode (
        .instr_i   (in_instr),
        .imm_o     (dec_imm),
        .type_o    (dec_type),
        .illegal_o (dec_illegal)
    );

    logic            out_valid_q,   out_valid_d;
    logic [XLEN-1:0] out_imm_q,     out_imm_d;
    logic [2:0]      out_type_q,    out_type_d;
    logic            out_illegal_q, out_illegal_d;
    logic            skid_valid_q,  skid_valid_d;
    logic [XLEN-1:0] skid_imm_q,    skid_imm_d;
    logic [2:0]      skid_type_q,   skid_type_d;
    logic            skid_illegal_q, skid_illegal_d;
    logic            in_fire;
    logic            out_free;

    // Entry update; the skid can only be occupied while in_ready is low,
    // so a skid refill and a new accept never coincide
    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_type_d     = out_type_q;
        out_illegal_d  = out_illegal_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_type_d    = skid_type_q;
        skid_illegal_d = skid_illegal_q;
        in_fire        = in_valid && !skid_valid_q && !flush;
        out_free       = !out_valid_q || out_ready;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d   = 1'b1;
                out_imm_d     = skid_imm_q;
                out_type_d    = skid_type_q;
                out_illegal_d = skid_illegal_q;
                skid_valid_d  = 1'b0;
            end else if (in_fire) begin
                out_valid_d   = 1'b1;
                out_imm_d     = dec_imm;
                out_type_d    = dec_type;
                out_illegal_d = dec_illegal;
            end else begin
                out_valid_d   = 1'b0;
            end
        end else begin
            if (in_fire) begin
                skid_valid_d   = 1'b1;
                skid_imm_d     = dec_imm;
                skid_type_d    = dec_type;
                skid_illegal_d = dec_illegal;
            end else begin
                skid_valid_d   = skid_valid_q;
            end
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_type_q     <= FMT_R;
            out_illegal_q  <= 1'b0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_type_q    <= FMT_R;
            skid_illegal_q <= 1'b0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_type_q     <= out_type_d;
            out_illegal_q  <= out_illegal_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_type_q    <= skid_type_d;
            skid_illegal_q <= skid_illegal_d;
        end
    end

    assign in_ready    = !skid_valid_q;
    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_type    = out_type_q;
    assign out_illegal = out_illegal_q;

endmodule

// File: tb/tb_immediate_decode_stage.sv
// Self-checking bench: XLEN=32 and XLEN=64 instances share one stimulus stream;
// directed scenarios plus a randomized run against a FIFO-of-two reference model.
module tb_immediate_decode_stage;

    localparam logic [2:0] T_R = 3'd0, T_I = 3'd1, T_S = 3'd2, T_B = 3'd3,
                           T_U = 3'd4, T_J = 3'd5, T_Z = 3'd6;

    typedef struct packed {
        logic        ill;
        logic [2:0]  ty;
        logic [63:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic        in_ready32, out_valid32, out_illegal32;
    logic [31:0] out_imm32;
    logic [2:0]  out_type32;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] out_imm64;
    logic [2:0]  out_type64;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    immediate_decode_stage #(.XLEN(32), .CSR_IMM_EN(1'b1)) dut32 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .out_valid(out_valid32), .out_ready(out_ready),
        .out_imm(out_imm32), .out_type(out_type32), .out_illegal(out_illegal32));

    immediate_decode_stage #(.XLEN(64), .CSR_IMM_EN(1'b1)) dut64 (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .out_valid(out_valid64), .out_ready(out_ready),
        .out_imm(out_imm64), .out_type(out_type64), .out_illegal(out_illegal64));

    // Reference decoder written from the instruction-set rules as integer arithmetic
    function automatic exp_t ref_decode(input logic [31:0] ins, input bit x64);
        exp_t   e;
        longint v;
        e.ill = 1'b0;
        e.ty  = T_R;
        v     = 0;
        if (ins[1:0] != 2'b11) begin
            e.ill = 1'b1;
        end else begin
            case (ins[6:0])
                7'h13: begin
                    e.ty = T_I;
                    if (ins[13:12] == 2'b01) v = x64 ? longint'(ins[25:20]) : longint'(ins[24:20]);
                    else v = longint'($signed(ins[31:20]));
                end
                7'h03, 7'h67: begin e.ty = T_I; v = longint'($signed(ins[31:20])); end
                7'h73: begin
                    if (ins[14:12] == 3'd0) e.ty = T_R;
                    else if (ins[14]) begin e.ty = T_Z; v = longint'(ins[19:15]); end
                    else begin e.ty = T_I; v = longint'($signed(ins[31:20])); end
                end
                7'h23: begin e.ty = T_S; v = longint'($signed({ins[31:25], ins[11:7]})); end
                7'h63: begin
                    e.ty = T_B;
                    v = longint'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
                end
                7'h37, 7'h17: begin e.ty = T_U; v = longint'($signed(ins[31:12])) * 4096; end
                7'h6F: begin
                    e.ty = T_J;
                    v = longint'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
                end
                7'h33, 7'h0F: e.ty = T_R;
                7'h1B: begin
                    if (x64) begin e.ty = T_I; v = longint'($signed(ins[31:20])); end
                    else e.ill = 1'b1;
                end
                7'h3B: begin if (x64) e.ty = T_R; else e.ill = 1'b1; end
                default: e.ill = 1'b1;
            endcase
        end
        if (e.ill) begin
            e.ty = T_R;
            v    = 0;
        end
        e.imm = v;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = 32'd0;
        tick(); tick();
        checks++;
        if (out_valid32 !== 1'b0 || out_imm32 !== 32'd0 || out_type32 !== T_R || out_illegal32 !== 1'b0) begin
            failures++;
            $display("FAIL reset32: got v=%b imm=%h t=%0d ill=%b, want 0 0 0 0", out_valid32, out_imm32, out_type32, out_illegal32);
        end
        checks++;
        if (out_valid64 !== 1'b0 || out_imm64 !== 64'd0 || out_type64 !== T_R || out_illegal64 !== 1'b0) begin
            failures++;
            $display("FAIL reset64: got v=%b imm=%h t=%0d ill=%b, want 0 0 0 0", out_valid64, out_imm64, out_type64, out_illegal64);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (in_ready32 !== 1'b1 || in_ready64 !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b/%b want 1/1", in_ready32, in_ready64);
        end
    endtask

    task automatic test_addi();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'hFFF00093;
        tick();
        in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b1 || out_imm32 !== 32'hFFFFFFFF || out_type32 !== T_I || out_illegal32 !== 1'b0) begin
            failures++;
            $display("FAIL addi: got v=%b imm=%h t=%0d ill=%b, want 1 ffffffff 1 0", out_valid32, out_imm32, out_type32, out_illegal32);
        end
        tick();
        checks++;
        if (out_valid32 !== 1'b0) begin
            failures++;
            $display("FAIL addi_drain: got out_valid=%b want 0", out_valid32);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ins [3];
        logic [31:0] imm [3];
        logic [2:0]  ty  [3];
        ins = '{32'hFE000EE3, 32'h0010006F, 32'h300FD073};
        imm = '{32'hFFFFFFFC, 32'h00000800, 32'h0000001F};
        ty  = '{T_B, T_J, T_Z};
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_instr = ins[i];
            tick();
            checks++;
            if (out_valid32 !== 1'b1 || out_imm32 !== imm[i] || out_type32 !== ty[i]) begin
                failures++;
                $display("FAIL stream[%0d]: got v=%b imm=%h t=%0d, want 1 %h %0d", i, out_valid32, out_imm32, out_type32, imm[i], ty[i]);
            end
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_xlen64();
        out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h80000037;
        tick();
        checks++;
        if (out_imm64 !== 64'hFFFFFFFF80000000 || out_type64 !== T_U || out_imm32 !== 32'h80000000) begin
            failures++;
            $display("FAIL lui64: got imm64=%h t=%0d imm32=%h, want ffffffff80000000 4 80000000", out_imm64, out_type64, out_imm32);
        end
        in_instr = 32'h03F01013;
        tick();
        checks++;
        if (out_imm64 !== 64'h3F || out_type64 !== T_I || out_imm32 !== 32'h1F) begin
            failures++;
            $display("FAIL slli63: got imm64=%h t=%0d imm32=%h, want 3f 1 1f", out_imm64, out_type64, out_imm32);
        end
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins [4];
        int          sent, got;
        bit          held_v, acc, del;
        logic [31:0] held_imm;
        ins = '{32'h00100093, 32'h00200093, 32'h00300093, 32'h00400093};
        sent = 0; got = 0; held_v = 1'b0; held_imm = 32'd0;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            in_valid  = (sent < 4);
            in_instr  = (sent < 4) ? ins[sent] : 32'd0;
            out_ready = (cyc >= 3);
            if (cyc == 2) begin
                checks++;
                if (in_ready32 !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_in_ready: got %b want 0 after two accepts", in_ready32);
                end
            end
            if (held_v) begin
                checks++;
                if (out_valid32 !== 1'b1 || out_imm32 !== held_imm) begin
                    failures++;
                    $display("FAIL bp_stable: got v=%b imm=%h want 1 %h", out_valid32, out_imm32, held_imm);
                end
            end
            acc = in_valid && in_ready32;
            del = out_valid32 && out_ready;
            if (del) begin
                checks++;
                if (out_imm32 !== 32'(got + 1)) begin
                    failures++;
                    $display("FAIL bp_order[%0d]: got imm=%h want %h", got, out_imm32, 32'(got + 1));
                end
                got++;
            end
            held_v   = out_valid32 && !out_ready;
            held_imm = out_imm32;
            if (acc) sent++;
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (got != 4 || sent != 4) begin
            failures++;
            $display("FAIL bp_count: got delivered=%0d accepted=%0d want 4 4", got, sent);
        end
        tick();
        checks++;
        if (out_valid32 !== 1'b0) begin
            failures++;
            $display("FAIL bp_no_dup: got out_valid=%b want 0", out_valid32);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0; in_valid = 1'b1;
        in_instr = 32'h00100093; tick();
        in_instr = 32'h00200093; tick();
        in_instr = 32'h00300093; flush = 1'b1; tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1) begin
            failures++;
            $display("FAIL flush_full: got v=%b/%b rdy=%b/%b want 0/0 1/1", out_valid32, out_valid64, in_ready32, in_ready64);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (out_valid32 !== 1'b0) begin
                failures++;
                $display("FAIL flush_dropped[%0d]: got out_valid=%b want 0", i, out_valid32);
            end
        end
        // Flush with an empty stage and a ready input: the offer must still be refused
        in_valid = 1'b1; in_instr = 32'h00500093; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b0) begin
            failures++;
            $display("FAIL flush_refuse: got out_valid=%b want 0", out_valid32);
        end
    endtask

    task automatic test_illegal_and_reset();
        logic [31:0] ins [2];
        ins = '{32'h00000000, 32'h0000007F};
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_instr = ins[i];
            tick();
            checks++;
            if (out_valid32 !== 1'b1 || out_illegal32 !== 1'b1 || out_imm32 !== 32'd0 || out_type32 !== T_R) begin
                failures++;
                $display("FAIL illegal[%0d]: got v=%b ill=%b imm=%h t=%0d want 1 1 0 0", i, out_valid32, out_illegal32, out_imm32, out_type32);
            end
        end
        out_ready = 1'b0;
        in_instr = 32'h12300093; tick();
        in_instr = 32'h45600093; tick();
        reset = 1'b1; in_instr = 32'h78900093;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid32 !== 1'b0 || out_imm32 !== 32'd0 || out_type32 !== T_R || out_illegal32 !== 1'b0 || in_ready32 !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset: got v=%b imm=%h t=%0d ill=%b rdy=%b want 0 0 0 0 1", out_valid32, out_imm32, out_type32, out_illegal32, in_ready32);
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_empty: got v=%b/%b want 0/0", out_valid32, out_valid64);
        end
    endtask

    task automatic test_random();
        exp_t        q32[$];
        exp_t        q64[$];
        exp_t        e;
        logic [6:0]  ops [15];
        logic [31:0] r;
        ops = '{7'h13, 7'h03, 7'h67, 7'h73, 7'h23, 7'h63, 7'h37, 7'h17,
                7'h6F, 7'h33, 7'h0F, 7'h1B, 7'h3B, 7'h7F, 7'h5B};
        for (int cyc = 0; cyc < 600; cyc++) begin
            r = $urandom;
            if ($urandom_range(15) != 0) r[6:0] = ops[$urandom_range(14)];
            in_instr  = r;
            in_valid  = ($urandom_range(3) != 0);
            out_ready = ($urandom_range(2) != 0);
            flush     = ($urandom_range(39) == 0);
            checks++;
            if (out_valid32 !== (q32.size() != 0) || in_ready32 !== (q32.size() < 2) ||
                out_valid64 !== (q64.size() != 0) || in_ready64 !== (q64.size() < 2)) begin
                failures++;
                $display("FAIL rnd_hs[%0d]: got v=%b/%b rdy=%b/%b with %0d queued", cyc, out_valid32, out_valid64, in_ready32, in_ready64, q32.size());
            end
            if (flush) begin
                q32.delete();
                q64.delete();
            end else begin
                if (in_valid && q32.size() < 2) begin
                    q32.push_back(ref_decode(r, 1'b0));
                    q64.push_back(ref_decode(r, 1'b1));
                end
                if (out_ready && q32.size() != 0 && (q32.size() > 1 || !(in_valid && q32.size() == 1 && 1'b0))) begin
                    // the head is the oldest entry, pushed earlier or already present
                end
            end
            if (!flush && out_ready && out_valid32 === 1'b1 && q32.size() != 0) begin
                e = q32.pop_front();
                checks++;
                if (out_imm32 !== e.imm[31:0] || out_type32 !== e.ty || out_illegal32 !== e.ill) begin
                    failures++;
                    $display("FAIL rnd32[%0d]: got imm=%h t=%0d ill=%b want %h %0d %b", cyc, out_imm32, out_type32, out_illegal32, e.imm[31:0], e.ty, e.ill);
                end
            end
            if (!flush && out_ready && out_valid64 === 1'b1 && q64.size() != 0) begin
                e = q64.pop_front();
                checks++;
                if (out_imm64 !== e.imm || out_type64 !== e.ty || out_illegal64 !== e.ill) begin
                    failures++;
                    $display("FAIL rnd64[%0d]: got imm=%h t=%0d ill=%b want %h %0d %b", cyc, out_imm64, out_type64, out_illegal64, e.imm, e.ty, e.ill);
                end
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        tick(); tick(); tick();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_stream();
        test_xlen64();
        test_back_to_back();
        test_flush();
        test_illegal_and_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
